// File: rtl/snake_pkg.sv
// Shared constants for the snake game: screen bounds, pixel field widths and
// arbiter phase encodings.
package snake_pkg;

  localparam int unsigned SCREEN_X_MAX = 159;
  localparam int unsigned SCREEN_Y_MAX = 119;
  localparam int unsigned X_W          = 8;
  localparam int unsigned Y_W          = 7;
  localparam int unsigned C_W          = 3;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ERASE = 2'd1,
    PH_DRAW  = 2'd2
  } phase_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set mask bit after i_ptr, wrapping,
// returned as a one-hot grant.
module rr_picker #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         i_mask,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant_c,
  output logic                 o_valid_c
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant_c = '0;
    o_valid_c = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % N);
      if (!o_valid_c && i_mask[w_idx]) begin
        o_grant_c[w_idx] = 1'b1;
        o_valid_c        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Owns the VGA plot port: sequences each frame as ERASE then DRAW and grants
// one pixel per handshake to the eligible requesters.
module plot_arbiter #(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned X_W         = snake_pkg::X_W,
  parameter int unsigned Y_W         = snake_pkg::Y_W,
  parameter int unsigned C_W         = snake_pkg::C_W,
  parameter int unsigned X_MAX       = snake_pkg::SCREEN_X_MAX,
  parameter int unsigned Y_MAX       = snake_pkg::SCREEN_Y_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       erase_done,
  input  logic                       draw_done,
  input  logic [NUM_CLIENTS-1:0]     req,
  input  logic [NUM_CLIENTS*X_W-1:0] req_x,
  input  logic [NUM_CLIENTS*Y_W-1:0] req_y,
  input  logic [NUM_CLIENTS*C_W-1:0] req_colour,
  output logic [NUM_CLIENTS-1:0]     ack,
  output logic                       plot,
  output logic [X_W-1:0]             out_x,
  output logic [Y_W-1:0]             out_y,
  output logic [C_W-1:0]             out_colour,
  output logic [1:0]                 phase,
  output logic                       frame_done,
  output logic                       overrun
);

  import snake_pkg::phase_e;
  import snake_pkg::PH_IDLE;
  import snake_pkg::PH_ERASE;
  import snake_pkg::PH_DRAW;

  localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);

  phase_e                 r_phase;
  logic [PTR_W-1:0]       r_ptr;
  logic [NUM_CLIENTS-1:0] r_ack;
  logic                   r_plot;
  logic [X_W-1:0]         r_x;
  logic [Y_W-1:0]         r_y;
  logic [C_W-1:0]         r_colour;
  logic                   r_frame_done;
  logic                   r_overrun;

  logic [NUM_CLIENTS-1:0] w_elig;
  logic [NUM_CLIENTS-1:0] w_mask;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic                   w_valid;
  logic [PTR_W-1:0]       w_win_idx;
  logic [X_W-1:0]         w_win_x;
  logic [Y_W-1:0]         w_win_y;
  logic [C_W-1:0]         w_win_c;
  logic                   w_clip;

  // Phase-end cycles issue no grant so the next phase starts with a clean port.
  always_comb begin
    w_elig = '0;
    case (r_phase)
      PH_ERASE: if (!erase_done) w_elig[0] = 1'b1;
      PH_DRAW: begin
        if (!draw_done) begin
          w_elig    = '1;
          w_elig[0] = 1'b0;
        end
      end
      default: w_elig = '0;
    endcase
  end

  assign w_mask = w_elig & req & ~r_ack;

  rr_picker #(.N(NUM_CLIENTS)) u_picker (
    .i_mask    (w_mask),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_valid_c (w_valid)
  );

  always_comb begin
    w_win_idx = '0;
    w_win_x   = '0;
    w_win_y   = '0;
    w_win_c   = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (w_grant[i]) begin
        w_win_idx = PTR_W'(i);
        w_win_x   = req_x[i*X_W +: X_W];
        w_win_y   = req_y[i*Y_W +: Y_W];
        w_win_c   = req_colour[i*C_W +: C_W];
      end
    end
  end

  assign w_clip = (32'(w_win_x) > X_MAX) || (32'(w_win_y) > Y_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase      <= PH_IDLE;
      r_ptr        <= PTR_W'(NUM_CLIENTS - 1);
      r_ack        <= '0;
      r_plot       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_ack        <= w_grant;
      r_plot       <= w_valid && !w_clip;
      r_frame_done <= 1'b0;
      // Clipped pixels are acked but leave the visible coordinates untouched.
      if (w_valid && !w_clip) begin
        r_x      <= w_win_x;
        r_y      <= w_win_y;
        r_colour <= w_win_c;
      end
      if (w_valid && r_phase == PH_DRAW) r_ptr <= w_win_idx;
      case (r_phase)
        PH_IDLE: if (frame_start) r_phase <= PH_ERASE;
        PH_ERASE: begin
          if (frame_start) r_overrun <= 1'b1;
          if (erase_done)  r_phase   <= PH_DRAW;
        end
        PH_DRAW: begin
          if (draw_done) begin
            r_frame_done <= 1'b1;
            r_phase      <= frame_start ? PH_ERASE : PH_IDLE;
          end else if (frame_start) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign ack        = r_ack;
  assign plot       = r_plot;
  assign out_x      = r_x;
  assign out_y      = r_y;
  assign out_colour = r_colour;
  assign phase      = r_phase;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter with three clients; outputs checked 1ns after each posedge.
module tb_plot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        erase_done;
  logic        draw_done;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  ack;
  logic        plot;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic [1:0]  phase;
  logic        frame_done;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  plot_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .erase_done  (erase_done),
    .draw_done   (draw_done),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_colour  (req_colour),
    .ack         (ack),
    .plot        (plot),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_colour  (out_colour),
    .phase       (phase),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int idx, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[idx*8 +: 8]      = x;
    req_y[idx*7 +: 7]      = y;
    req_colour[idx*3 +: 3] = c;
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; erase_done = 1'b0; draw_done = 1'b0;
    req = 3'b000; req_x = '0; req_y = '0; req_colour = '0;

    // Reset state
    step();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // Enter ERASE
    rst = 1'b1; frame_start = 1'b1;
    step();
    chk("erase_enter", 32'(phase), 32'd1);
    frame_start = 1'b0;

    // ERASE: only client 0 served, every second cycle
    set_pix(0, 8'd5, 7'd7, 3'd0);
    set_pix(1, 8'd20, 7'd30, 3'd5);
    set_pix(2, 8'd40, 7'd50, 3'd6);
    req = 3'b011;
    step();
    chk("er_ack_a", 32'(ack), 32'd1);
    chk("er_plot_a", 32'(plot), 32'd1);
    chk("er_x_a", 32'(out_x), 32'd5);
    chk("er_y_a", 32'(out_y), 32'd7);
    step();
    chk("er_ack_b", 32'(ack), 32'd0);
    chk("er_plot_b", 32'(plot), 32'd0);
    chk("er_x_hold", 32'(out_x), 32'd5);
    step();
    chk("er_ack_c", 32'(ack), 32'd1);
    chk("er_plot_c", 32'(plot), 32'd1);
    step();
    chk("er_ack_d", 32'(ack), 32'd0);

    // frame_start while in ERASE
    req = 3'b010; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_phase", 32'(phase), 32'd1);
    chk("ovr_no_ack", 32'(ack), 32'd0);

    // Grant before erase end, then erase_done with a new pixel pending
    req = 3'b011; set_pix(0, 8'd9, 7'd3, 3'd1);
    step();
    chk("pre_end_ack", 32'(ack), 32'd1);
    chk("pre_end_x", 32'(out_x), 32'd9);
    set_pix(0, 8'd11, 7'd4, 3'd2); erase_done = 1'b1;
    step();
    erase_done = 1'b0;
    chk("erase_end_phase", 32'(phase), 32'd2);
    chk("erase_end_ack", 32'(ack), 32'd0);
    chk("erase_end_plot", 32'(plot), 32'd0);
    chk("erase_end_x", 32'(out_x), 32'd9);

    // DRAW round robin: clients 1 and 2 alternate, client 1 first
    req = 3'b110;
    step();
    chk("rr_ack_1", 32'(ack), 32'd2);
    chk("rr_x_1", 32'(out_x), 32'd20);
    chk("rr_y_1", 32'(out_y), 32'd30);
    chk("rr_c_1", 32'(out_colour), 32'd5);
    step();
    chk("rr_ack_2", 32'(ack), 32'd4);
    chk("rr_x_2", 32'(out_x), 32'd40);
    chk("rr_plot_2", 32'(plot), 32'd1);
    step();
    chk("rr_ack_3", 32'(ack), 32'd2);
    chk("rr_x_3", 32'(out_x), 32'd20);
    step();
    chk("rr_ack_4", 32'(ack), 32'd4);
    chk("rr_y_4", 32'(out_y), 32'd50);

    // Clipping
    req = 3'b010; set_pix(1, 8'd160, 7'd10, 3'd3);
    step();
    chk("clip_ack", 32'(ack), 32'd2);
    chk("clip_plot", 32'(plot), 32'd0);
    chk("clip_x_hold", 32'(out_x), 32'd40);
    set_pix(1, 8'd159, 7'd119, 3'd4);
    step();
    chk("clip_gap_ack", 32'(ack), 32'd0);
    step();
    chk("edge_ack", 32'(ack), 32'd2);
    chk("edge_plot", 32'(plot), 32'd1);
    chk("edge_x", 32'(out_x), 32'd159);
    chk("edge_y", 32'(out_y), 32'd119);

    // draw_done suppresses the pending client 2 grant
    req = 3'b110; draw_done = 1'b1;
    step();
    draw_done = 1'b0; req = 3'b000;
    chk("draw_end_phase", 32'(phase), 32'd0);
    chk("draw_end_fd", 32'(frame_done), 32'd1);
    chk("draw_end_ack", 32'(ack), 32'd0);
    chk("draw_end_plot", 32'(plot), 32'd0);
    step();
    chk("fd_pulse_end", 32'(frame_done), 32'd0);

    // Reset in the middle of DRAW with a request pending
    frame_start = 1'b1;
    step();
    frame_start = 1'b0; erase_done = 1'b1;
    step();
    erase_done = 1'b0;
    chk("redraw_phase", 32'(phase), 32'd2);
    req = 3'b010; set_pix(1, 8'd77, 7'd66, 3'd7);
    step();
    chk("pre_rst_ack", 32'(ack), 32'd2);
    rst = 1'b0;
    step();
    chk("mid_rst_phase", 32'(phase), 32'd0);
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_x", 32'(out_x), 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_plot", 32'(plot), 32'd0);
    chk("post_rst_ack", 32'(ack), 32'd0);
    req = 3'b000;

    // draw_done together with frame_start restarts at ERASE
    frame_start = 1'b1;
    step();
    frame_start = 1'b0; erase_done = 1'b1;
    step();
    erase_done = 1'b0;
    draw_done = 1'b1; frame_start = 1'b1;
    step();
    draw_done = 1'b0; frame_start = 1'b0;
    chk("b2b_phase", 32'(phase), 32'd1);
    chk("b2b_fd", 32'(frame_done), 32'd1);
    chk("b2b_ovr", 32'(overrun), 32'd0);

    // frame_start in DRAW without draw_done
    erase_done = 1'b1;
    step();
    erase_done = 1'b0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("draw_ovr", 32'(overrun), 32'd1);
    chk("draw_ovr_phase", 32'(phase), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
